// File: rtl/wb_stage_pkg.sv
// Shared types and codes for the MIPS32 writeback stage.
// Optional bypass outputs are enabled by defining WB_BYPASS_EN.
package wb_stage_pkg;

   localparam int WORD_WIDTH = 32;
   localparam int REG_ADDR_W = 5;

   localparam logic [REG_ADDR_W-1:0] REG_ZERO  = '0;
   localparam logic [WORD_WIDTH-1:0] ZERO_WORD = '0;

   localparam logic [2:0] LOAD_LB  = 3'b000;
   localparam logic [2:0] LOAD_LH  = 3'b001;
   localparam logic [2:0] LOAD_LW  = 3'b010;
   localparam logic [2:0] LOAD_LBU = 3'b100;
   localparam logic [2:0] LOAD_LHU = 3'b101;

   typedef enum logic {
      WB_IDLE = 1'b0,
      WB_WAIT = 1'b1
   } wb_state_t;

endpackage

// File: rtl/wb_stage_load_align.sv
// Little-endian load data extraction and alignment check.
// Purely combinational so the MEM stage can reuse it.
module wb_stage_load_align
   import wb_stage_pkg::*;
#(
   parameter int W = WORD_WIDTH
) (
   input  logic [W-1:0] rdata,
   input  logic [1:0]   offset,
   input  logic [2:0]   load_type,
   output logic [W-1:0] data,
   output logic         err
);

   logic [7:0]  b;
   logic [15:0] h;

   always_comb begin
      b = 8'h00;
      unique case (offset)
         2'd0: b = rdata[7:0];
         2'd1: b = rdata[15:8];
         2'd2: b = rdata[23:16];
         2'd3: b = rdata[31:24];
      endcase
      h = offset[1] ? rdata[31:16] : rdata[15:0];
   end

   always_comb begin
      data = rdata;
      err  = 1'b0;
      case (load_type)
         LOAD_LB:  data = {{(W-8){b[7]}}, b};
         LOAD_LBU: data = {{(W-8){1'b0}}, b};
         LOAD_LH: begin
            data = {{(W-16){h[15]}}, h};
            err  = offset[0];
         end
         LOAD_LHU: begin
            data = {{(W-16){1'b0}}, h};
            err  = offset[0];
         end
         LOAD_LW:  err = |offset;
         default:  err = 1'b1;
      endcase
   end

endmodule

// File: rtl/wb_stage.sv
// MIPS32 writeback stage: waits on load responses, registers the GPR write.
// Define WB_BYPASS_EN to expose the committing value on fwd_* ports.
module wb_stage
   import wb_stage_pkg::*;
#(
   parameter int W  = WORD_WIDTH,
   parameter int RW = REG_ADDR_W
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic          in_write_en,
   input  logic [RW-1:0] in_write_addr,
   input  logic [W-1:0]  in_result,
   input  logic          in_is_load,
   input  logic [2:0]    in_load_type,
   input  logic [W-1:0]  dmem_rdata,
   input  logic          dmem_rvalid,
   output logic          rf_write_en,
   output logic [RW-1:0] rf_write_addr,
   output logic [W-1:0]  rf_write_data,
   output logic          misalign_err,
   output logic          retired
`ifdef WB_BYPASS_EN
   ,
   output logic          fwd_valid,
   output logic [RW-1:0] fwd_addr,
   output logic [W-1:0]  fwd_data
`endif
);

   wb_state_t     state;
   logic          lat_wen;
   logic [RW-1:0] lat_addr;
   logic [1:0]    lat_off;
   logic [2:0]    lat_type;

   logic          xfer;
   logic          commit;
   logic          c_load;
   logic          c_wen;
   logic [RW-1:0] c_addr;
   logic [1:0]    c_off;
   logic [2:0]    c_type;
   logic [W-1:0]  c_data;
   logic          c_err;
   logic          c_we;
   logic [W-1:0]  al_data;
   logic          al_err;

   assign in_ready = (state == WB_IDLE) & ~rst;
   assign xfer     = in_valid & in_ready;

   always_comb begin
      if (state == WB_WAIT) begin
         commit = dmem_rvalid;
         c_load = 1'b1;
         c_wen  = lat_wen;
         c_addr = lat_addr;
         c_off  = lat_off;
         c_type = lat_type;
      end else begin
         commit = xfer & (~in_is_load | dmem_rvalid);
         c_load = in_is_load;
         c_wen  = in_write_en;
         c_addr = in_write_addr;
         c_off  = in_result[1:0];
         c_type = in_load_type;
      end
   end

   wb_stage_load_align #(.W(W)) u_align (
      .rdata     (dmem_rdata),
      .offset    (c_off),
      .load_type (c_type),
      .data      (al_data),
      .err       (al_err)
   );

   assign c_err  = c_load & al_err;
   assign c_data = c_load ? al_data : in_result;
   assign c_we   = commit & c_wen & ~c_err
                 & (c_addr != RW'(REG_ZERO));

`ifdef WB_BYPASS_EN
   assign fwd_valid = c_we;
   assign fwd_addr  = c_addr;
   assign fwd_data  = c_data;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= WB_IDLE;
         lat_wen       <= 1'b0;
         lat_addr      <= '0;
         lat_off       <= 2'd0;
         lat_type      <= 3'd0;
         rf_write_en   <= 1'b0;
         rf_write_addr <= '0;
         rf_write_data <= W'(ZERO_WORD);
         misalign_err  <= 1'b0;
         retired       <= 1'b0;
      end else begin
         rf_write_en  <= c_we;
         misalign_err <= commit & c_err;
         retired      <= commit;
         if (commit) begin
            rf_write_addr <= c_addr;
            rf_write_data <= c_data;
         end
         unique case (state)
            WB_IDLE: begin
               // Load accepted without its data: park it until rvalid.
               if (xfer && in_is_load && !dmem_rvalid) begin
                  state    <= WB_WAIT;
                  lat_wen  <= in_write_en;
                  lat_addr <= in_write_addr;
                  lat_off  <= in_result[1:0];
                  lat_type <= in_load_type;
               end
            end
            WB_WAIT: begin
               if (dmem_rvalid) state <= WB_IDLE;
            end
         endcase
      end
   end

endmodule
